// File: rtl/spi_cmd_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_regfile_if
// Description : Command/response channel between the SPI stack and the
//               command-processing register file.
//               recv_* : command word from the SPI stack (val/rdy)
//               send_* : response word toward the SPI stack (val/rdy)
//               cmd_count : number of completed responses (wraps at 256)
//               slave  modport : register-file side
//               master modport : SPI-stack / driver side
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_cmd_regfile_if #(
    parameter int NBITS = 30
) ();
    logic             recv_val;
    logic             recv_rdy;
    logic [NBITS-1:0] recv_msg;
    logic             send_val;
    logic             send_rdy;
    logic [NBITS-1:0] send_msg;
    logic [7:0]       cmd_count;

    modport slave (
        input  recv_val,
        input  recv_msg,
        input  send_rdy,
        output recv_rdy,
        output send_val,
        output send_msg,
        output cmd_count
    );

    modport master (
        output recv_val,
        output recv_msg,
        output send_rdy,
        input  recv_rdy,
        input  send_val,
        input  send_msg,
        input  cmd_count
    );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_regfile
// Description : Executes SPI command words against a 16-entry register file
//               and returns exactly one response word per command.
//               Command word : {op[1:0], addr[3:0], data[NBITS-7:0]}
//               Response word: {op, addr, result}
//               op 00 WRITE, 01 READ, 10 ACCUM, 11 SUM(reg[0..addr]).
//               Ports:
//                 clk   - single clock
//                 reset - asynchronous, active-high
//                 bus   - slave side of spi_cmd_regfile_if
//               NBITS must be at least 8.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_regfile #(
    parameter int NBITS = 30
) (
    input  wire logic            clk,
    input  wire logic            reset,
    spi_cmd_regfile_if.slave     bus
);
    localparam int DBITS = NBITS - 6;

    localparam logic [1:0] C_OP_WRITE = 2'b00;
    localparam logic [1:0] C_OP_READ  = 2'b01;
    localparam logic [1:0] C_OP_ACCUM = 2'b10;
    localparam logic [1:0] C_OP_SUM   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [3:0]         addr_q, addr_d;
    logic [3:0]         idx_q, idx_d;
    logic [DBITS-1:0]   acc_q, acc_d;
    logic [NBITS-1:0]   send_msg_q, send_msg_d;
    logic [7:0]         cmd_count_q, cmd_count_d;
    logic [DBITS-1:0]   regs_q [16];

    // Command field decode
    logic [1:0]         w_cmd_op;
    logic [3:0]         w_cmd_addr;
    logic [DBITS-1:0]   w_cmd_data;
    logic [DBITS-1:0]   w_rd_cmd;
    logic [DBITS-1:0]   w_accum;
    logic [DBITS-1:0]   w_exec_sum;
    logic               w_reg_we;
    logic [DBITS-1:0]   w_reg_wdata;

    assign w_cmd_op   = bus.recv_msg[NBITS-1:NBITS-2];
    assign w_cmd_addr = bus.recv_msg[NBITS-3:NBITS-6];
    assign w_cmd_data = bus.recv_msg[NBITS-7:0];

    // Read port for the incoming command; carries out of DBITS are dropped.
    assign w_rd_cmd   = regs_q[w_cmd_addr];
    assign w_accum    = w_rd_cmd + w_cmd_data;
    assign w_exec_sum = acc_q + regs_q[idx_q];

    // Next-state / datapath control
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        send_msg_d  = send_msg_q;
        cmd_count_d = cmd_count_q;
        w_reg_we    = 1'b0;
        w_reg_wdata = w_cmd_data;

        case (state_q)
            S_IDLE: begin
                if (bus.recv_val) begin
                    op_d   = w_cmd_op;
                    addr_d = w_cmd_addr;
                    case (w_cmd_op)
                        C_OP_WRITE: begin
                            w_reg_we    = 1'b1;
                            w_reg_wdata = w_cmd_data;
                            send_msg_d  = {w_cmd_op, w_cmd_addr, w_cmd_data};
                            state_d     = S_RESP;
                        end
                        C_OP_READ: begin
                            send_msg_d  = {w_cmd_op, w_cmd_addr, w_rd_cmd};
                            state_d     = S_RESP;
                        end
                        C_OP_ACCUM: begin
                            w_reg_we    = 1'b1;
                            w_reg_wdata = w_accum;
                            send_msg_d  = {w_cmd_op, w_cmd_addr, w_accum};
                            state_d     = S_RESP;
                        end
                        C_OP_SUM: begin
                            acc_d   = '0;
                            idx_d   = 4'd0;
                            state_d = S_EXEC;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_EXEC: begin
                acc_d = w_exec_sum;
                // Terminate on the last index rather than on idx wrap, so
                // addr=15 finishes without idx ever rolling past 15.
                if (idx_q == addr_q) begin
                    send_msg_d = {op_q, addr_q, w_exec_sum};
                    state_d    = S_RESP;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_RESP: begin
                if (bus.send_rdy) begin
                    cmd_count_d = cmd_count_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            addr_q      <= 4'd0;
            idx_q       <= 4'd0;
            acc_q       <= '0;
            send_msg_q  <= '0;
            cmd_count_q <= 8'd0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            send_msg_q  <= send_msg_d;
            cmd_count_q <= cmd_count_d;
            if (w_reg_we) begin
                regs_q[w_cmd_addr] <= w_reg_wdata;
            end
        end
    end

    // Handshake outputs come from the state register; recv_rdy is also held
    // low while reset is asserted.
    assign bus.recv_rdy  = (state_q == S_IDLE) && !reset;
    assign bus.send_val  = (state_q == S_RESP);
    assign bus.send_msg  = send_msg_q;
    assign bus.cmd_count = cmd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_regfile
// Description : Directed self-checking bench for spi_cmd_regfile. Expected
//               responses are queued when a command is driven and compared
//               when the response appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_regfile;
    localparam int NBITS = 30;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    int   resp_cyc = 0;
    logic [NBITS-1:0] sb [$];

    spi_cmd_regfile_if #(.NBITS(NBITS)) bus ();

    spi_cmd_regfile #(.NBITS(NBITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive one command, wait for its response, compare against the
    // scoreboard, optionally hold send_rdy low with a spurious command
    // pending, then complete the handshake.
    task automatic do_cmd(input logic [NBITS-1:0] msg, input logic [NBITS-1:0] exp_msg,
                          input int exp_lat, input int hold);
        int n;
        int lat;
        logic [NBITS-1:0] exp_q;
        n = 0;
        while (bus.recv_rdy !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("recv_rdy_wait", (n < 100), 1);
        bus.recv_val = 1'b1;
        bus.recv_msg = msg;
        sb.push_back(exp_msg);
        tick();
        bus.recv_val = 1'b0;
        if (hold > 0) bus.send_rdy = 1'b0;
        lat = 1;
        while (bus.send_val !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        if (exp_lat > 0) chk("latency", lat, exp_lat);
        exp_q = sb.pop_front();
        chk("send_msg", bus.send_msg, exp_q);
        for (int i = 0; i < hold; i++) begin
            bus.recv_val = 1'b1;
            bus.recv_msg = 30'h09123456;
            tick();
            chk("bp_msg_stable", bus.send_msg, exp_q);
            chk("bp_recv_rdy", bus.recv_rdy, 0);
            chk("bp_send_val", bus.send_val, 1);
        end
        bus.recv_val = 1'b0;
        bus.send_rdy = 1'b1;
        resp_cyc = cyc;
        tick();
        exp_count++;
        chk("cmd_count", bus.cmd_count, exp_count % 256);
        chk("send_val_drop", bus.send_val, 0);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        chk("rst_recv_rdy", bus.recv_rdy, 0);
        reset = 1'b0;
        exp_count = 0;
        tick();
        chk("post_rst_recv_rdy", bus.recv_rdy, 1);
    endtask

    initial begin
        logic [NBITS-1:0] m;
        int prev;
        int seen;
        reset        = 1'b1;
        bus.recv_val = 1'b0;
        bus.recv_msg = '0;
        bus.send_rdy = 1'b1;
        tick();
        tick();
        chk("rst_recv_rdy", bus.recv_rdy, 0);
        chk("rst_send_val", bus.send_val, 0);
        chk("rst_send_msg", bus.send_msg, 0);
        chk("rst_cmd_count", bus.cmd_count, 0);
        reset = 1'b0;
        tick();
        chk("rel_recv_rdy", bus.recv_rdy, 1);

        // All registers read back as zero after reset
        for (int a = 0; a < 16; a++) begin
            m = {2'b01, 4'(a), 24'h0};
            do_cmd(m, m, 1, 0);
        end

        // Fill with all-ones and SUM over all 16 entries
        for (int a = 0; a < 16; a++) begin
            m = {2'b00, 4'(a), 24'hFFFFFF};
            do_cmd(m, m, 1, 0);
        end
        do_cmd(30'h3F000000, 30'h3FFFFFF0, 17, 0);

        // Reset in the middle of a SUM: the response is dropped
        bus.recv_val = 1'b1;
        bus.recv_msg = 30'h3F000000;
        tick();
        bus.recv_val = 1'b0;
        tick();
        tick();
        chk("exec_recv_rdy", bus.recv_rdy, 0);
        reset = 1'b1;
        #1;
        chk("midrst_send_val", bus.send_val, 0);
        chk("midrst_recv_rdy", bus.recv_rdy, 0);
        tick();
        tick();
        reset = 1'b0;
        exp_count = 0;
        tick();
        chk("midrst_rel_recv_rdy", bus.recv_rdy, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.send_val === 1'b1) seen++;
            tick();
        end
        chk("midrst_no_resp", seen, 0);
        chk("midrst_cmd_count", bus.cmd_count, 0);
        do_cmd(30'h1F000000, 30'h1F000000, 1, 0);

        // WRITE then READ
        reset_pulse();
        do_cmd(30'h0500ABCD, 30'h0500ABCD, 1, 0);
        do_cmd(30'h15000000, 30'h1500ABCD, 1, 0);
        chk("wr_rd_count", bus.cmd_count, 2);

        // ACCUM wraps at 2^24
        do_cmd(30'h03FFFFFF, 30'h03FFFFFF, 1, 0);
        do_cmd(30'h23000002, 30'h23000001, 1, 0);
        do_cmd(30'h13000000, 30'h13000001, 1, 0);

        // SUM latency over regs 0..3 = 1,2,3,4
        do_cmd(30'h00000001, 30'h00000001, 1, 0);
        do_cmd(30'h01000002, 30'h01000002, 1, 0);
        do_cmd(30'h02000003, 30'h02000003, 1, 0);
        do_cmd(30'h03000004, 30'h03000004, 1, 0);
        do_cmd(30'h33000000, 30'h3300000A, 5, 0);

        // Backpressure with a spurious WRITE to reg9 offered meanwhile
        do_cmd(30'h15000000, 30'h1500ABCD, 1, 10);
        do_cmd(30'h19000000, 30'h19000000, 1, 0);

        // 256 back-to-back READs: count wraps, responses 2 cycles apart
        reset_pulse();
        prev = 0;
        for (int i = 0; i < 256; i++) begin
            m = {2'b01, 4'(i % 16), 24'h0};
            do_cmd(m, m, 1, 0);
            if (i > 0) chk("spacing", resp_cyc - prev, 2);
            prev = resp_cyc;
        end
        chk("count_wrap", bus.cmd_count, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_cmd_regfile.md
# spi_cmd_regfile

Command-processing register file that sits directly downstream of the SPI stack's val/rdy interface inside the tapeout block. It consumes each command word the SPI minion delivers (`recv_*`), executes it against a 16-entry register file, and returns exactly one response word per command on the SPI stack's return path (`send_*`). At most one command is in flight at a time. The multi-cycle SUM command gives the host a deterministic latency to measure over SPI.

## Interface
- `nbits`, default 30: command/response width; must be ≥ 8. This is the SPI payload, excluding the two flow-control bits.
- `dbits`, derived as `nbits-6`, default 24: data field width.

Ports:
- `clk`  in  1  single clock for all state.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `recv_val`  in  1  command valid from the SPI stack.
- `recv_rdy`  out  1  block can accept a command.
- `recv_msg`  in  nbits  command word: op=`[nbits-1:nbits-2]`, addr=`[nbits-3:nbits-6]`, data=`[nbits-7:0]`.
- `send_val`  out  1  response valid toward the SPI stack.
- `send_rdy`  in  1  SPI stack accepts the response.
- `send_msg`  out  nbits  response word: `{op, addr, result}`.
- `cmd_count`  out  8  number of completed responses; wraps at 256.

## Operation
- Storage: `reg[0..15]`, each dbits wide.
- Opcodes:
  - `00` WRITE: `reg[addr] <= data`; result = data.
  - `01` READ: result = `reg[addr]`; no state change.
  - `10` ACCUM: `reg[addr] <= (reg[addr] + data) mod 2^dbits`; result = the new value.
  - `11` SUM: result = `(reg[0] + … + reg[addr]) mod 2^dbits`; evaluated one register per cycle.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - `recv_rdy` = 1.
  - On `recv_val && recv_rdy`, latch op and addr.
  - WRITE/ACCUM update the register file at this same edge.
  - Non-SUM ops load `send_msg` and go to RESP.
  - SUM clears the accumulator, clears the index to 0 and goes to EXEC.
- EXEC:
  - Each cycle: `acc += reg[idx]`, `idx++`.
  - After adding `reg[addr]`, load `send_msg` from the accumulator and go to RESP.
- RESP:
  - `send_val` = 1 and `send_msg` is held stable.
  - On `send_rdy`: go to IDLE and `cmd_count++`.
- `recv_rdy` is 0 in EXEC and RESP. `recv_val` in those states is ignored and not latched.
- Accumulator arithmetic is dbits wide; carries beyond dbits are discarded.
- Reset mid-operation (any state):
  - Abort, drop the pending response and return to IDLE.
  - Clear all registers and `cmd_count`.

## Timing
- Reset values:
  - State IDLE; `send_val` = 0; `send_msg` = 0; `cmd_count` = 0; all `reg` = 0.
  - `recv_rdy` = 0 while `reset` is high, and 1 in the first cycle after deassertion.
- `recv_rdy` and `send_val` are decoded from the state register only. There is no combinational path from `recv_val` or `send_rdy` to any output.
- Latency is counted from the accepting edge E:
  - WRITE/READ/ACCUM: `send_val` is high in the cycle after E.
  - SUM with addr=k: EXEC lasts k+1 cycles, so `send_val` rises k+2 cycles after E.
- After the response handshake edge, `recv_rdy` = 1 in the next cycle. Peak throughput is one non-SUM command per 2 cycles.
- READ immediately after WRITE/ACCUM to the same address returns the updated value.
- `send_msg` changes only when entering RESP. It is stable for any number of `send_rdy`=0 cycles.
- `cmd_count` increments on the RESP handshake edge; 255→0.
- SUM addr=15 takes 16 EXEC cycles; the index must not wrap before termination.

## Test plan
- Reset mid-op:
  - After reset release: `send_val`=0, `send_msg`=0, `cmd_count`=0, and READ of all 16 addresses returns 0.
  - Assert reset during EXEC of SUM: no response; `recv_rdy`=1 the cycle after release.
- WRITE/READ:
  - WRITE `0x0500ABCD` → `send_msg`=`0x0500ABCD`, one cycle after accept.
  - Then READ `0x15000000` → `0x1500ABCD`; `cmd_count`=2.
- ACCUM wrap:
  - WRITE `0x03FFFFFF`, then ACCUM `0x23000002` → `0x23000001`.
  - READ reg3 → `0x13000001`.
- SUM latency:
  - regs 0..3 = 1, 2, 3, 4; SUM `0x33000000` → `0x3300000A`, with `send_val` rising 5 cycles after accept.
  - SUM addr 15 with all regs `0xFFFFFF` → data `0xFFFFF0`.
- Backpressure:
  - Hold `send_rdy`=0 for 10 cycles during a READ response: `send_msg` stable, `recv_rdy`=0.
  - Drive a second `recv_val` during those cycles: it is ignored, and exactly one response is produced.
- Counter wrap:
  - 256 back-to-back READs with `send_rdy`=1 → `cmd_count` returns to 0.
  - Every response is spaced exactly 2 cycles apart.
